// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel coordinates, end-of-frame strobe and frame count; re-aligns sync/DE with renderer RGB.
// Pins lag their coordinate by PIX_LAT+1 enabled cycles; every register holds while ce=0.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BP     = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 38,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PIX_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  output logic signed [11:0] oX_video,
  output logic signed [11:0] oY_video,
  output logic               endFrame,
  output logic [31:0]        frame_cnt,
  input  logic [7:0]         iR_video,
  input  logic [7:0]         iG_video,
  input  logic [7:0]         iB_video,
  output logic [7:0]         vga_r,
  output logic [7:0]         vga_g,
  output logic [7:0]         vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL >= 2048 || V_TOTAL >= 2048) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be below 2048");
    end
    if (PIX_LAT < 1 || PIX_LAT > 8) begin : g_bad_lat
      $error("vga_timing_gen: PIX_LAT must be in 1..8");
    end
  endgenerate

  logic [10:0] x;
  logic [10:0] y;
  logic        last_x;
  logic        last_y;
  logic        de_raw;
  logic        hs_raw;
  logic        vs_raw;

  logic [PIX_LAT-1:0] de_d;
  logic [PIX_LAT-1:0] hs_d;
  logic [PIX_LAT-1:0] vs_d;

  assign last_x = (x == 11'(H_TOTAL - 1));
  assign last_y = (y == 11'(V_TOTAL - 1));

  assign oX_video = $signed({1'b0, x});
  assign oY_video = $signed({1'b0, y});
  assign endFrame = ce && last_x && last_y;

  assign de_raw = (x < 11'(H_ACTIVE)) && (y < 11'(V_ACTIVE));
  assign hs_raw = (x >= 11'(H_ACTIVE + H_FP)) && (x < 11'(H_ACTIVE + H_FP + H_SYNC));
  // Decoded from Y alone, so vsync edges coincide with the X wrap.
  assign vs_raw = (y >= 11'(V_ACTIVE + V_FP)) && (y < 11'(V_ACTIVE + V_FP + V_SYNC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
    end else if (ce) begin
      if (last_x) begin
        x <= '0;
        if (last_y) begin
          y         <= '0;
          frame_cnt <= frame_cnt + 32'd1;
        end else begin
          y <= y + 11'd1;
        end
      end else begin
        x <= x + 11'd1;
      end
    end
  end

  // Timing flags ride alongside the renderer pipeline so they meet its RGB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_d <= '0;
      hs_d <= '0;
      vs_d <= '0;
    end else if (ce) begin
      de_d[0] <= de_raw;
      hs_d[0] <= hs_raw;
      vs_d[0] <= vs_raw;
      for (int i = 1; i < PIX_LAT; i++) begin
        de_d[i] <= de_d[i-1];
        hs_d[i] <= hs_d[i-1];
        vs_d[i] <= vs_d[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_de <= 1'b0;
      vga_hs <= ~HS_POL;
      vga_vs <= ~VS_POL;
    end else if (ce) begin
      vga_de <= de_d[PIX_LAT-1];
      vga_hs <= hs_d[PIX_LAT-1] ? HS_POL : ~HS_POL;
      vga_vs <= vs_d[PIX_LAT-1] ? VS_POL : ~VS_POL;
      vga_r  <= de_d[PIX_LAT-1] ? iR_video : 8'd0;
      vga_g  <= de_d[PIX_LAT-1] ? iG_video : 8'd0;
      vga_b  <= de_d[PIX_LAT-1] ? iB_video : 8'd0;
    end
  end

endmodule
